// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch path: widths, instruction field slices,
// opcode values and the fetch controller state encoding.
package isa_pkg;

  localparam int INSTR_W = 13;
  localparam int ADDR_W  = 4;

  localparam int OPC_MSB = 12;
  localparam int OPC_LSB = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 2;
  localparam int RT_MSB  = 1;
  localparam int RT_LSB  = 0;

  localparam logic [6:0] OPC_ADD  = 7'b0000010;
  localparam logic [6:0] OPC_DEC  = 7'b0000110;
  localparam logic [6:0] OPC_LOAD = 7'b0010000;
  localparam logic [6:0] OPC_ADDI = 7'b1000010;
  localparam logic [6:0] OPC_BRZ  = 7'b1100000;
  localparam logic [6:0] OPC_JUMP = 7'b1110000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_LOAD = 2'd1,
    FS_RUN  = 2'd2
  } fetch_state_t;

  function automatic logic [6:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: load has priority over increment; increment wraps modulo 2**ADDR_W.
module pc_reg #(
  parameter int                ADDR_W   = isa_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program-load streaming into instruction memory, then PC-driven
// fetch into the IF/ID register with stall and redirect handling.
//
//   state   | meaning
//   FS_IDLE | waiting for LOAD_EN (priority) or START
//   FS_LOAD | writing LOAD_DATA to memory at the load counter on LOAD_VALID
//   FS_RUN  | fetching; left only by reset
module instr_fetch_unit
  import isa_pkg::fetch_state_t, isa_pkg::FS_IDLE, isa_pkg::FS_LOAD, isa_pkg::FS_RUN;
#(
  parameter int                ADDR_W   = isa_pkg::ADDR_W,
  parameter int                INSTR_W  = isa_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               load_en,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_done,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_wr,
  output logic [ADDR_W-1:0]  imem_a,
  output logic [INSTR_W-1:0] imem_d,
  input  logic [INSTR_W-1:0] imem_q,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               running
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] pc, pc_load_val;
  logic              pc_load, pc_inc;
  logic              load_fin, fetch_take, fetch_kill;

  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    load_fin    = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = RESET_PC;
    pc_inc      = 1'b0;
    fetch_take  = 1'b0;
    fetch_kill  = 1'b0;
    imem_wr     = 1'b0;
    imem_a      = pc;
    imem_d      = '0;
    case (state)
      FS_IDLE: begin
        if (load_en) begin
          state_nxt = FS_LOAD;
          cnt_nxt   = '0;
        end else if (start) begin
          state_nxt  = FS_RUN;
          pc_load    = 1'b1;
          fetch_kill = 1'b1;
        end
      end
      FS_LOAD: begin
        imem_a  = cnt;
        imem_d  = load_data;
        imem_wr = load_valid;
        // a write to the last address ends the load, so the counter never wraps
        load_fin = !load_en || (load_valid && (cnt == LAST_ADDR));
        if (load_valid && (cnt != LAST_ADDR)) cnt_nxt = cnt + 1'b1;
        if (load_fin) state_nxt = FS_IDLE;
      end
      FS_RUN: begin
        if (redirect) begin
          pc_load     = 1'b1;
          pc_load_val = redirect_pc;
          fetch_kill  = 1'b1;
        end else if (!stall) begin
          pc_inc     = 1'b1;
          fetch_take = 1'b1;
        end
      end
      default: state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FS_IDLE;
      cnt       <= '0;
      load_done <= 1'b0;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_instr  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      load_done <= load_fin;
      if (fetch_kill) begin
        if_valid <= 1'b0;
      end else if (fetch_take) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_instr <= imem_q;
      end
    end
  end

  assign running = (state == FS_RUN);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instruction memory and
// a scoreboard of expected IF/ID and status outputs per clock.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic        v;
    logic [3:0]  pc;
    logic [12:0] instr;
    logic        done;
    logic        run;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, load_en, load_valid, stall, redirect;
  logic [12:0] load_data;
  logic [3:0]  redirect_pc;
  logic        load_done, imem_wr, if_valid, running;
  logic [3:0]  imem_a, if_pc;
  logic [12:0] imem_d, imem_q, if_instr;

  logic [12:0] mem [16];
  logic        mem_ready;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];

  int          m_state;
  logic [3:0]  m_pc, m_cnt, m_ifpc;
  logic        m_ifv;
  logic [12:0] m_ifi;
  logic [12:0] exp_mem [16];

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .load_en     (load_en),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_done   (load_done),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_wr     (imem_wr),
    .imem_a      (imem_a),
    .imem_d      (imem_d),
    .imem_q      (imem_q),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .running     (running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= 13'h1F00 | 13'(i);
    end else if (imem_wr) begin
      mem[imem_a] <= imem_d;
    end
  end

  assign imem_q = mem[imem_a];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle_inputs();
    start = 0; load_en = 0; load_valid = 0; load_data = '0;
    stall = 0; redirect = 0; redirect_pc = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 0;
    drive_idle_inputs();
    #1;
    check("rst_if_valid", if_valid, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_load_done", load_done, 0);
    check("rst_running", running, 0);
    check("rst_imem_wr", imem_wr, 0);
    check("rst_imem_a", imem_a, 0);
    m_state = 0; m_pc = 0; m_cnt = 0; m_ifv = 0; m_ifpc = 0; m_ifi = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic step(input logic st, input logic le, input logic lv, input logic [12:0] ld,
                      input logic stl, input logic rd, input logic [3:0] rpc);
    exp_t e;
    logic fin;
    @(negedge clk);
    start = st; load_en = le; load_valid = lv; load_data = ld;
    stall = stl; redirect = rd; redirect_pc = rpc;
    #1;
    if (m_state == 1) begin
      check("load_imem_wr", imem_wr, lv);
      check("load_imem_a", imem_a, m_cnt);
      check("load_imem_d", imem_d, ld);
    end else begin
      check("imem_wr", imem_wr, 0);
      check("imem_a", imem_a, m_pc);
    end
    e.done = 0;
    case (m_state)
      0: begin
        if (le) begin
          m_state = 1; m_cnt = 0;
        end else if (st) begin
          m_state = 2; m_pc = 0; m_ifv = 0;
        end
      end
      1: begin
        fin = !le || (lv && m_cnt == 4'd15);
        if (lv) begin
          exp_mem[m_cnt] = ld;
          m_cnt = m_cnt + 4'd1;
        end
        if (fin) begin
          m_state = 0; e.done = 1;
        end
      end
      default: begin
        if (rd) begin
          m_pc = rpc; m_ifv = 0;
        end else if (!stl) begin
          m_ifi = exp_mem[m_pc]; m_ifpc = m_pc; m_ifv = 1; m_pc = m_pc + 4'd1;
        end
      end
    endcase
    e.v = m_ifv; e.pc = m_ifpc; e.instr = m_ifi; e.run = (m_state == 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("if_valid", if_valid, e.v);
    check("if_pc", if_pc, e.pc);
    check("if_instr", if_instr, e.instr);
    check("load_done", load_done, e.done);
    check("running", running, e.run);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    rst_n = 0;
    mem_ready = 0;
    drive_idle_inputs();
    for (int i = 0; i < 16; i++) exp_mem[i] = 13'h1F00 | 13'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_ready = 1;
    do_reset();

    // full 16-word load, LOAD_EN held through the last write
    step(0, 1, 0, '0, 0, 0, '0);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 13'h1000 + 13'(i), 0, 0, '0);
    step(0, 0, 0, '0, 0, 0, '0);

    // readback and free-running wrap: 18 fetches give IF_PC 0..15,0,1
    step(1, 0, 0, '0, 0, 0, '0);
    run(18);
    step(1, 1, 1, 13'h0777, 0, 0, '0);
    run(1);
    // stall at PC=4 with IF_PC=3
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1, 0, '0);
    run(2);

    // reset mid-RUN at PC=6, then restart from address 0
    do_reset();
    step(1, 0, 0, '0, 0, 0, '0);
    run(2);
    // redirect with simultaneous stall at PC=2
    step(0, 0, 0, '0, 1, 1, 4'd11);
    run(2);

    // partial load: LOAD_EN drops after 3 words, with a gap cycle
    do_reset();
    step(0, 1, 0, '0, 0, 0, '0);
    step(0, 1, 1, 13'h0AA0, 0, 0, '0);
    step(0, 1, 0, 13'h1555, 0, 0, '0);
    step(0, 1, 1, 13'h0AA1, 0, 0, '0);
    step(0, 1, 1, 13'h0AA2, 0, 0, '0);
    step(0, 0, 0, '0, 0, 0, '0);
    step(0, 0, 0, '0, 0, 0, '0);
    step(1, 0, 0, '0, 0, 0, '0);
    run(5);

    // final write coincides with LOAD_EN falling
    do_reset();
    step(0, 1, 0, '0, 0, 0, '0);
    for (int i = 0; i < 15; i++) step(0, 1, 1, 13'h0500 + 13'(i), 0, 0, '0);
    step(0, 0, 1, 13'h050F, 0, 0, '0);
    step(0, 0, 0, '0, 0, 0, '0);
    step(1, 0, 0, '0, 0, 0, '0);
    step(0, 0, 0, '0, 0, 1, 4'd14);
    run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the 16x13 instruction memory. Owns the program counter, drives the memory address and write port, and registers each fetched word into an IF/ID register for the decoder.
- Also provides a program-load mode that streams up to 16 instruction words into the memory through its WR/D_IN port before execution starts.
- Handles stall from the decoder and redirect (BRZ taken / JUMP) from execute.

Parameters:
- ADDR_W, 4, PC and memory address width; memory depth is 2**ADDR_W.
- INSTR_W, 13, instruction width: opcode[12:6], rd[5:4], rs[3:2], rt/imm[1:0].
- RESET_PC, 0, PC value loaded on reset and on entry to RUN.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse; IDLE->RUN.
- LOAD_EN  in  1  level; IDLE->LOAD while high.
- LOAD_VALID  in  1  LOAD_DATA valid this cycle.
- LOAD_DATA  in  INSTR_W  word to write.
- LOAD_DONE  out  1  one-cycle pulse when LOAD finishes.
- STALL  in  1  decoder cannot accept; hold.
- REDIRECT  in  1  taken branch/jump from execute.
- REDIRECT_PC  in  ADDR_W  target address.
- IMEM_WR  out  1  memory write enable.
- IMEM_A  out  ADDR_W  memory address.
- IMEM_D  out  INSTR_W  memory write data.
- IMEM_Q  in  INSTR_W  memory read data, combinational on IMEM_A.
- IF_VALID  out  1  IF_INSTR/IF_PC hold a real instruction.
- IF_PC  out  ADDR_W  address of IF_INSTR.
- IF_INSTR  out  INSTR_W  registered instruction.
- RUNNING  out  1  state==RUN.

Behaviour:
- Reset (async, RST_N=0):
  - State IDLE.
  - PC=RESET_PC, load counter=0.
  - IF_VALID=0, IF_PC=0, IF_INSTR=0.
  - LOAD_DONE=0, RUNNING=0.
  - Outputs are reset values while RST_N is low. Reset mid-LOAD or mid-RUN abandons the operation; memory contents already written are kept.
- State IDLE:
  - IMEM_WR=0, IMEM_A=PC.
  - LOAD_EN=1 -> LOAD, with counter cleared.
  - Otherwise START=1 -> RUN, with PC=RESET_PC and IF_VALID=0.
  - LOAD_EN has priority over START.
- State LOAD:
  - IMEM_A=counter, IMEM_D=LOAD_DATA, IMEM_WR=LOAD_VALID.
  - Each LOAD_VALID cycle writes one word and increments counter.
  - After the write to address 15, or when LOAD_EN falls, pulse LOAD_DONE for 1 cycle and return to IDLE.
  - If the final write and the LOAD_EN fall coincide, the write still happens and LOAD_DONE pulses once.
  - Counter never wraps within one load.
- State RUN:
  - IMEM_WR=0, IMEM_A=PC, RUNNING=1.
  - Priority per clock edge: REDIRECT > STALL > normal.
  - Normal: IF_INSTR<=IMEM_Q, IF_PC<=PC, IF_VALID<=1, PC<=PC+1. The PC wraps 15->0 silently, modulo 2**ADDR_W.
  - STALL (no REDIRECT): PC, IF_INSTR, IF_PC and IF_VALID all hold.
  - REDIRECT: PC<=REDIRECT_PC, IF_VALID<=0, which inserts a one-cycle bubble. This applies even if STALL=1. IF_INSTR and IF_PC hold.
  - Fetch latency: a word is visible on IF_INSTR one cycle after its PC is presented. Redirect penalty is 1 bubble.
  - RUN is exited only by reset.
- START or LOAD_EN outside IDLE is ignored.

Decomposition:
- Package isa_pkg:
  - INSTR_W, ADDR_W.
  - Field slices: OPC_MSB/LSB, RD/RS/RT.
  - Opcode constants: ADD=7'b0000010, DEC=7'b0000110, LOAD=7'b0010000, ADDI=7'b1000010, BRZ=7'b1100000, JUMP=7'b1110000.
  - Fetch state encoding: IDLE/LOAD/RUN.
- One natural sub-module, pc_reg: PC register with hold, load and increment-with-wrap controls. This keeps next-PC priority logic separate from the load/run FSM.

Test Plan:
- Reset mid-RUN at PC=6 -> all outputs reset next sample; START then refetches from address 0 with IF_VALID=0 for the first cycle.
- LOAD_EN=1 with 16 LOAD_VALID words 0x1000+i -> IMEM_WR on 16 cycles at addresses 0..15, LOAD_DONE pulses once, state IDLE. Readback in RUN gives IF_INSTR=0x1000+i with IF_PC=i.
- LOAD_EN drops after 3 words -> only addresses 0..2 written, LOAD_DONE single pulse, address 3 unchanged.
- RUN free-running from 0 for 18 cycles -> IF_PC sequence 0..15,0,1; IF_VALID=1 from cycle 2.
- STALL high 3 cycles at PC=4 -> IF_PC=3 held, PC=4 held, then resumes 4,5.
- REDIRECT to 11 with STALL=1 simultaneously at PC=2 -> next IF_VALID=0, following IF_PC=11 with IF_INSTR=memory[11].
